alu_step_ctrl: RTL and testbench
================================

Name: alu_step_ctrl

Overview:
- Sequencer and arbiter for the shared ±5 ALU, which takes two 5-bit operand inputs, a 1-bit op select (0 = −5, 1 = +5) and an input select `iseq`, and produces a 6-bit result whose sign bit flags out-of-range.
- Two requesters each ask for a walk of N steps of ±5 from a start value.
- The block grants one requester at a time (round-robin) and iterates the ALU once per cycle, feeding back the result.
- It reports the final value, or an error when the ALU sign bit flags an out-of-range step.

Parameters:
- SIZE, 5, operand width; ALU result is SIZE+1 bits.
- CNT_W, 3, step-count width (0..7 steps).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-channel request, level; held until ack.
- op0  in  SIZE  ch0 start value.
- op1  in  SIZE  ch1 start value.
- dir0  in  1  ch0 direction: 0 = −5, 1 = +5.
- dir1  in  1  ch1 direction.
- cnt0  in  CNT_W  ch0 step count.
- cnt1  in  CNT_W  ch1 step count.
- ack  out  2  one-cycle completion pulse, one-hot per channel.
- result  out  SIZE  final value; valid while ack is high.
- err  out  1  out-of-range flag; valid while ack is high.
- busy  out  1  high in BUSY and DONE.
- alu_in1  out  SIZE  ALU in1 (ch0 path).
- alu_in2  out  SIZE  ALU in2 (ch1 path).
- alu_op  out  1  ALU op select.
- alu_iseq  out  1  ALU input select: 0 = in1, 1 = in2.
- alu_res  in  SIZE+1  ALU result.
- alu_sign  in  1  ALU sign (alu_res[SIZE]).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=ch0.
  - acc, remaining-count, chan, dir, err_r = 0.
  - All outputs 0, including ack, result, err, busy and all ALU drive.
  - Reset mid-operation abandons the job with no ack; the requester re-issues.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On any req bit, grant a channel. If only one bit is set, that channel wins. If both are set, the rr pointer wins.
  - Latch acc←op, rem←cnt, dir, chan; clear err_r.
  - If cnt==0, go to DONE; otherwise go to BUSY.
  - req sampled here is cycle T.
- BUSY, one ALU step per cycle:
  - Drive alu_op=dir and alu_iseq=chan.
  - Drive acc on alu_in1 when chan=0, or on alu_in2 when chan=1; the unused input is 0.
  - If alu_sign==0: acc←alu_res[SIZE-1:0], rem←rem−1. When rem==1, go to DONE.
  - If alu_sign==1 (result <0 or >31): err_r←1, acc unchanged, go to DONE immediately.
- DONE:
  - ack[chan]=1, result=acc, err=err_r, all for exactly one cycle.
  - rr pointer←~chan; go to IDLE.
- Latency:
  - N≥1 steps without error: ack at cycle T+N+1.
  - N=0: ack at T+1, result=op, no ALU activity.
- ALU drive outputs are 0 outside BUSY. busy is low in IDLE.
- Handshake rules:
  - op, dir and cnt must stay stable while req is high; they are only sampled in IDLE.
  - A requester deasserts req in the cycle after ack. A req still high in the IDLE cycle following DONE is treated as a new job.
  - req changes during BUSY are ignored.
- Arithmetic: the ALU is combinational; the block trusts alu_sign as the overflow/underflow indicator. No wrap-around is ever written to acc.

Optional Feature:
- Macro: ALU_STEP_SAT_EN.
- Defined: on alu_sign==1, acc saturates (0 if dir=0, 31 if dir=1), err_r←1 (sticky), rem decrements, and stepping continues until rem is exhausted. Latency is always N+1.
- Undefined: abort-on-error as described in Behaviour.

Decomposition:
- Package alu_step_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - ALU op constants OP_SUB=0, OP_ADD=1.
  - STEP=5, SAT_MIN=0, SAT_MAX=31.
- Sub-module alu_rr_arb: 2-way round-robin arbiter with inputs req[1:0], the pointer and an update strobe; output one-hot grant.

Test Plan:
- ch0 op=10, dir=1, cnt=3 → alu_iseq=0 in BUSY; alu_in1 sequence 10, 15, 20; ack[0] at T+4, result=25, err=0.
- ch1 op=12, dir=0, cnt=2 → alu_iseq=1; alu_in2 sequence 12, 7; ack[1] at T+3, result=2, err=0.
- ch0 op=7, dir=0, cnt=3 → step 1 gives 2, step 2 has sign=1; ack at T+3, result=2, err=1. With ALU_STEP_SAT_EN: ack at T+4, result=0, err=1.
- Both req after reset, each cnt=1 → ch0 acked first, then ch1. Both re-asserted → ch0 first again, since the pointer returned to ch0. ack is never 2'b11.
- ch1 cnt=0, op=17 → ack[1] at T+1, result=17, ALU drive stays 0.
- rst_n low during BUSY on the second step → all outputs 0 immediately, no ack. After release with req still high → job restarts from op.

Source files
------------

// File: rtl/alu_step_ctrl_pkg.sv
// alu_step_pkg
//   Shared types and constants for the +/-5 ALU step sequencer.
//   state_t  : controller FSM states
//   OP_*     : ALU op select encodings
//   STEP     : magnitude of one ALU step
//   SAT_*    : clamp values used when ALU_STEP_SAT_EN is defined
package alu_step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SUB  = 1'b0;
    localparam logic OP_ADD  = 1'b1;

    localparam int   STEP    = 5;
    localparam int   SAT_MIN = 0;
    localparam int   SAT_MAX = 31;

    // One-hot completion vector for a channel index.
    function automatic logic [1:0] chan_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_step_ctrl_arb.sv
// alu_rr_arb
//   Two-way round-robin arbiter. Purely combinational; the pointer is held
//   by the caller and only advanced once a job completes.
//   req   : per-channel request levels
//   ptr   : channel that wins when both request
//   upd   : grant strobe; grant is all-zero while low
//   grant : one-hot grant
module alu_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       upd,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (upd) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_step_ctrl.sv
// alu_step_ctrl
//   Sequencer/arbiter for a shared +/-5 ALU. Two requesters each ask for a
//   walk of cnt steps from a start value; one job runs at a time and the ALU
//   result is fed back once per cycle.
//
//   Optional macro ALU_STEP_SAT_EN: out-of-range steps saturate the
//   accumulator and stepping continues; otherwise the job aborts on the
//   first out-of-range step.
//
//   Ports
//   clk, rst_n            : clock, async active-low reset
//   req[1:0]              : per-channel request level, held until ack
//   op0/op1, dir0/dir1,
//   cnt0/cnt1             : per-channel start value, direction, step count
//   ack[1:0]              : one-cycle one-hot completion pulse
//   result, err           : final value and out-of-range flag, valid with ack
//   busy                  : high in BUSY and DONE
//   alu_in1/alu_in2,
//   alu_op, alu_iseq      : ALU drive, zero outside BUSY
//   alu_res, alu_sign     : ALU result and its out-of-range sign bit
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration and operand capture
//   BUSY  | one ALU step per cycle, result fed back into acc
//   DONE  | ack pulse with result/err, advance round-robin pointer
module alu_step_ctrl
    import alu_step_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [SIZE-1:0]  op0,
    input  logic [SIZE-1:0]  op1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    output logic [1:0]       ack,
    output logic [SIZE-1:0]  result,
    output logic             err,
    output logic             busy,
    output logic [SIZE-1:0]  alu_in1,
    output logic [SIZE-1:0]  alu_in2,
    output logic             alu_op,
    output logic             alu_iseq,
    input  logic [SIZE:0]    alu_res,
    input  logic             alu_sign
);

    state_t           state;
    logic             rr_ptr;
    logic             chan;
    logic             dir_r;
    logic             err_r;
    logic [SIZE-1:0]  acc;
    logic [CNT_W-1:0] rem;

    logic [1:0]       grant;
    logic             sel_ch;
    logic [SIZE-1:0]  op_sel;
    logic             dir_sel;
    logic [CNT_W-1:0] cnt_sel;

    logic [SIZE-1:0]  acc_nxt;
    logic [CNT_W-1:0] rem_nxt;
    logic             err_nxt;
    logic             finish;

    // The sign bit arrives separately on alu_sign, which is the one trusted.
    logic             unused_res_msb;
    assign unused_res_msb = alu_res[SIZE];

    alu_rr_arb u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .upd   (state == IDLE),
        .grant (grant)
    );

    assign sel_ch  = grant[1];
    assign op_sel  = sel_ch ? op1  : op0;
    assign dir_sel = sel_ch ? dir1 : dir0;
    assign cnt_sel = sel_ch ? cnt1 : cnt0;

    // Next accumulator for the current BUSY step.
    always_comb begin
        acc_nxt = acc;
        rem_nxt = rem;
        err_nxt = err_r;
        finish  = 1'b0;
`ifdef ALU_STEP_SAT_EN
        rem_nxt = rem - 1'b1;
        finish  = (rem == CNT_W'(1));
        if (alu_sign) begin
            acc_nxt = (dir_r == OP_ADD) ? SIZE'(SAT_MAX) : SIZE'(SAT_MIN);
            err_nxt = 1'b1;
        end else begin
            acc_nxt = alu_res[SIZE-1:0];
        end
`else
        if (alu_sign) begin
            // Abort: the wrapped ALU value is never written back.
            err_nxt = 1'b1;
            finish  = 1'b1;
        end else begin
            acc_nxt = alu_res[SIZE-1:0];
            rem_nxt = rem - 1'b1;
            finish  = (rem == CNT_W'(1));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            chan     <= 1'b0;
            dir_r    <= 1'b0;
            err_r    <= 1'b0;
            acc      <= '0;
            rem      <= '0;
            ack      <= 2'b00;
            result   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_op   <= 1'b0;
            alu_iseq <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        chan  <= sel_ch;
                        dir_r <= dir_sel;
                        acc   <= op_sel;
                        rem   <= cnt_sel;
                        err_r <= 1'b0;
                        busy  <= 1'b1;
                        if (cnt_sel == '0) begin
                            state  <= DONE;
                            ack    <= chan_onehot(sel_ch);
                            result <= op_sel;
                            err    <= 1'b0;
                        end else begin
                            state    <= BUSY;
                            alu_op   <= dir_sel;
                            alu_iseq <= sel_ch;
                            alu_in1  <= sel_ch ? '0 : op_sel;
                            alu_in2  <= sel_ch ? op_sel : '0;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    rem   <= rem_nxt;
                    err_r <= err_nxt;
                    if (finish) begin
                        state    <= DONE;
                        ack      <= chan_onehot(chan);
                        result   <= acc_nxt;
                        err      <= err_nxt;
                        alu_in1  <= '0;
                        alu_in2  <= '0;
                        alu_op   <= 1'b0;
                        alu_iseq <= 1'b0;
                    end else begin
                        alu_in1 <= chan ? '0 : acc_nxt;
                        alu_in2 <= chan ? acc_nxt : '0;
                    end
                end
                DONE: begin
                    ack    <= 2'b00;
                    result <= '0;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    rr_ptr <= ~chan;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_step_ctrl.sv
module tb_alu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [4:0] op0, op1;
    logic       dir0, dir1;
    logic [2:0] cnt0, cnt1;
    logic [1:0] ack;
    logic [4:0] result;
    logic       err;
    logic       busy;
    logic [4:0] alu_in1, alu_in2;
    logic       alu_op, alu_iseq;
    logic [5:0] alu_res;
    logic       alu_sign;

    always #5 clk = ~clk;

    // Behavioural ALU: selected input +/-5 in 6 bits, bit 5 flags out of range.
    logic [4:0] alu_sel;
    assign alu_sel  = alu_iseq ? alu_in2 : alu_in1;
    assign alu_res  = alu_op ? ({1'b0, alu_sel} + 6'd5) : ({1'b0, alu_sel} - 6'd5);
    assign alu_sign = alu_res[5];

    alu_step_ctrl #(.SIZE(5), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .op0(op0), .op1(op1), .dir0(dir0), .dir1(dir1),
        .cnt0(cnt0), .cnt1(cnt1),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_iseq(alu_iseq),
        .alu_res(alu_res), .alu_sign(alu_sign)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]      ack;
        logic [4:0]      res;
        logic            err;
        logic            dir;
        logic [3:0]      nsteps;
        logic [7:0][4:0] vals;
        logic [31:0]     cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic mptr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference walk: plain integer arithmetic over the step rules.
    function automatic exp_t model(input logic ch, input int op, input logic d,
                                   input int n, input int unsigned start);
        exp_t e;
        int   v, nv;
        logic stop;
        e        = '0;
        e.ack    = ch ? 2'b10 : 2'b01;
        e.dir    = d;
        e.nsteps = 4'(n);
        v        = op;
        stop     = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!stop) begin
                e.vals[i] = v[4:0];
                nv = d ? v + 5 : v - 5;
                if (nv < 0 || nv > 31) begin
                    e.err = 1'b1;
`ifdef ALU_STEP_SAT_EN
                    v = d ? 31 : 0;
`else
                    stop     = 1'b1;
                    e.nsteps = 4'(i + 1);
`endif
                end else begin
                    v = nv;
                end
            end
        end
        e.res = v[4:0];
        e.cyc = start + 32'(e.nsteps) + 1;
        return e;
    endfunction

    // Monitor: pops on ack, checks ALU drive step by step during BUSY.
    exp_t       me;
    int         ms = 0;
    logic [4:0] m_used, m_unused;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ms = 0;
        end else if (ack != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 0);
            end else begin
                me = q.pop_front();
                chk("ack_onehot", 32'(ack), 32'(me.ack));
                chk("result", 32'(result), 32'(me.res));
                chk("err", 32'(err), 32'(me.err));
                chk("ack_cycle", cyc, me.cyc);
                chk("done_busy", 32'(busy), 1);
                chk("done_alu_zero", 32'({alu_in1, alu_in2, alu_op, alu_iseq}), 0);
            end
            ms = 0;
        end else if (busy) begin
            if (q.size() == 0) begin
                chk("busy_without_job", 32'(busy), 0);
            end else begin
                me       = q[0];
                m_used   = me.ack[1] ? alu_in2 : alu_in1;
                m_unused = me.ack[1] ? alu_in1 : alu_in2;
                chk("alu_iseq", 32'(alu_iseq), 32'(me.ack[1]));
                chk("alu_op", 32'(alu_op), 32'(me.dir));
                chk("alu_unused_in", 32'(m_unused), 0);
                chk("alu_used_in", 32'(m_used), 32'(me.vals[ms < 8 ? ms : 7]));
                ms++;
            end
        end else begin
            chk("idle_outputs_zero",
                32'({ack, result, err, alu_in1, alu_in2, alu_op, alu_iseq}), 0);
        end
    end

    task automatic issue(input logic [1:0] r, input int a0, input int a1,
                         input logic d0, input logic d1, input int n0, input int n1);
        exp_t        e1, e2;
        logic        first;
        int unsigned c;
        op0 = 5'(a0); op1 = 5'(a1);
        dir0 = d0;    dir1 = d1;
        cnt0 = 3'(n0); cnt1 = 3'(n1);
        c = cyc;
        req = r;
        if (r == 2'b11) begin
            first = mptr;
            e1 = model(first, first ? a1 : a0, first ? d1 : d0, first ? n1 : n0, c);
            e2 = model(~first, first ? a0 : a1, first ? d0 : d1, first ? n0 : n1, e1.cyc + 1);
            q.push_back(e1);
            q.push_back(e2);
        end else if (r == 2'b10) begin
            q.push_back(model(1'b1, a1, d1, n1, c));
            mptr = 1'b0;
        end else begin
            q.push_back(model(1'b0, a0, d0, n0, c));
            mptr = 1'b1;
        end
    endtask

    // Requesters drop their bit right after seeing ack; ends in an IDLE cycle.
    task automatic drain();
        int k = 0;
        while ((q.size() != 0 || req != 2'b00) && k < 300) begin
            @(negedge clk); #2;
            req = req & ~ack;
            k++;
        end
        chk("drain_in_budget", 32'(k < 300), 1);
        if (k >= 300) begin
            q.delete();
            req = 2'b00;
        end
        @(negedge clk); #2;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 32'({ack, result, err, busy, alu_in1, alu_in2, alu_op, alu_iseq}), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mptr  = 1'b0;
        req   = 2'b00;
        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk); #2;
    endtask

    initial begin
        req = 2'b00; op0 = '0; op1 = '0; dir0 = 1'b0; dir1 = 1'b0; cnt0 = '0; cnt1 = '0;
        do_reset();

        // Both request after reset: ch0 first, then ch1; repeat gives ch0 first again.
        issue(2'b11, 3, 20, 1'b1, 1'b0, 1, 1);
        drain();
        issue(2'b11, 30, 1, 1'b1, 1'b0, 1, 1);
        drain();

        issue(2'b01, 10, 0, 1'b1, 1'b0, 3, 0);   // 10,15,20 -> 25
        drain();
        issue(2'b10, 0, 12, 1'b0, 1'b0, 0, 2);   // 12,7 -> 2
        drain();
        issue(2'b01, 7, 0, 1'b0, 1'b0, 3, 0);    // 2 then out of range
        drain();
        issue(2'b10, 0, 17, 1'b0, 1'b1, 0, 0);   // zero steps
        drain();
        issue(2'b01, 28, 0, 1'b1, 1'b0, 2, 0);   // upper bound crossing
        drain();

        // Reset during the second BUSY step, request held through reset.
        issue(2'b01, 10, 0, 1'b1, 1'b0, 3, 0);
        @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        mptr  = 1'b0;
        #1;
        check_all_zero("reset_mid_job");
        @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        q.push_back(model(1'b0, 10, 1'b1, 3, cyc));
        mptr = 1'b1;
        drain();

        for (int it = 0; it < 40; it++) begin
            issue(2'($urandom_range(1, 3)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
